// File: rtl/puf_challenge_sequencer.sv
// Sequences challenges into an arbiter PUF array: NREP launch/settle/sample
// rounds per challenge, per-instance majority vote, XOR-combined output bit.
module puf_challenge_sequencer #(
    parameter int N      = 64,
    parameter int K      = 4,
    parameter int NREP   = 3,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [N-1:0] chal_in,
    output logic [N-1:0] puf_chal,
    output logic         puf_launch,
    input  logic [K-1:0] puf_resp,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [K-1:0] resp_raw,
    output logic         resp_out,
    output logic         busy
);

    localparam int VW = (NREP > 1) ? $clog2(NREP + 1) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int SL = (SETTLE > 0) ? SETTLE - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t state, next;

    logic [SW-1:0] settle_cnt;
    logic [VW-1:0] eval_cnt;
    logic [VW-1:0] vote     [K];
    logic [VW-1:0] vote_nxt [K];
    logic [K-1:0]  raw_nxt;
    logic          accept;
    logic          eval_last;

    assign eval_last  = (eval_cnt == VW'(NREP - 1));
    assign chal_ready = (state == S_IDLE) && !rst;
    assign puf_launch = (state == S_LAUNCH);
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next   = state;
        accept = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (chal_valid) begin
                    accept = 1'b1;
                    next   = S_LAUNCH;
                end
            end
            S_LAUNCH: next = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) next = S_SAMPLE;
            S_SAMPLE: next = eval_last ? S_DONE : S_LAUNCH;
            S_DONE:   if (resp_ready) next = S_IDLE;
            default:  next = S_IDLE;
        endcase
    end

    // Votes including the current sample, so the final round feeds the decision
    always_comb begin
        for (int i = 0; i < K; i++) begin
            vote_nxt[i] = vote[i] + VW'(puf_resp[i]);
            raw_nxt[i]  = (vote_nxt[i] > VW'(NREP / 2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            puf_chal   <= '0;
            settle_cnt <= '0;
            eval_cnt   <= '0;
            resp_raw   <= '0;
            resp_out   <= 1'b0;
            for (int i = 0; i < K; i++) vote[i] <= '0;
        end else begin
            if (accept) begin
                puf_chal <= chal_in;
                eval_cnt <= '0;
                for (int i = 0; i < K; i++) vote[i] <= '0;
            end
            if (state == S_LAUNCH) begin
                settle_cnt <= SW'(SL);
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
            if (state == S_SAMPLE) begin
                eval_cnt <= eval_cnt + VW'(1);
                for (int i = 0; i < K; i++) vote[i] <= vote_nxt[i];
                if (eval_last) begin
                    resp_raw <= raw_nxt;
                    resp_out <= ^raw_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: default build (3 votes, settle 4) and a NREP=1/SETTLE=0
// build, with a per-build PUF model that only shows the right bits at sample time.
module tb_puf_challenge_sequencer;

    localparam int SA = 4;
    localparam int SB = 0;

    typedef struct {
        logic [3:0] raw;
        logic       out;
        int         t0;
        int         lat;
        int         nl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic        a_cv = 0, a_rdy, a_launch, a_rr = 1, a_valid, a_out, a_busy;
    logic [63:0] a_in = 0, a_pchal;
    logic [3:0]  a_resp = 0, a_raw;
    logic        b_cv = 0, b_rdy, b_launch, b_rr = 1, b_valid, b_out, b_busy;
    logic [63:0] b_in = 0, b_pchal;
    logic [3:0]  b_resp = 0, b_raw;

    logic [3:0] a_seq [3];
    logic [3:0] b_seq;
    int a_nl = 0, a_k = -1, a_ll = 0;
    int b_nl = 0, b_k = -1;
    logic a_vp = 0, b_vp = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;

    puf_challenge_sequencer #(.N(64), .K(4), .NREP(3), .SETTLE(SA)) dut_a (
        .clk(clk), .rst(rst), .chal_valid(a_cv), .chal_ready(a_rdy),
        .chal_in(a_in), .puf_chal(a_pchal), .puf_launch(a_launch),
        .puf_resp(a_resp), .resp_valid(a_valid), .resp_ready(a_rr),
        .resp_raw(a_raw), .resp_out(a_out), .busy(a_busy)
    );

    puf_challenge_sequencer #(.N(64), .K(4), .NREP(1), .SETTLE(SB)) dut_b (
        .clk(clk), .rst(rst), .chal_valid(b_cv), .chal_ready(b_rdy),
        .chal_in(b_in), .puf_chal(b_pchal), .puf_launch(b_launch),
        .puf_resp(b_resp), .resp_valid(b_valid), .resp_ready(b_rr),
        .resp_raw(b_raw), .resp_out(b_out), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // PUF models: correct bits only in the sample cycle, inverted otherwise
    always @(negedge clk) begin
        if (!a_busy) begin
            a_nl = 0; a_k = -1; a_resp = 4'hF;
        end else if (a_launch) begin
            if (a_nl > 0) chk("a_launch_gap", 64'(edge_cnt - a_ll), SA + 2);
            a_ll = edge_cnt;
            a_nl++;
            a_k = 0;
            a_resp = ~a_seq[a_nl-1];
        end else if (a_k >= 0) begin
            a_k++;
            a_resp = (a_k == SA + 1) ? a_seq[a_nl-1] : ~a_seq[a_nl-1];
        end
    end

    always @(negedge clk) begin
        if (!b_busy) begin
            b_nl = 0; b_k = -1; b_resp = 4'hF;
        end else if (b_launch) begin
            b_nl++;
            b_k = 0;
            b_resp = ~b_seq;
        end else if (b_k >= 0) begin
            b_k++;
            b_resp = (b_k == SB + 1) ? b_seq : ~b_seq;
        end
    end

    always @(negedge clk) begin
        if (a_valid && !a_vp) begin
            if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("a_resp_raw", a_raw, ea.raw);
                chk("a_resp_out", a_out, ea.out);
                chk("a_latency", 64'(edge_cnt - ea.t0), ea.lat);
                chk("a_launches", a_nl, ea.nl);
            end
        end
        a_vp = a_valid;
    end

    always @(negedge clk) begin
        if (b_valid && !b_vp) begin
            if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("b_resp_raw", b_raw, eb.raw);
                chk("b_resp_out", b_out, eb.out);
                chk("b_latency", 64'(edge_cnt - eb.t0), eb.lat);
                chk("b_launches", b_nl, eb.nl);
            end
        end
        b_vp = b_valid;
    end

    task automatic issue_a(input logic [63:0] c, input logic [3:0] s0,
                           input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] er, input logic eo,
                           input bit push);
        exp_t e;
        @(negedge clk);
        a_seq[0] = s0; a_seq[1] = s1; a_seq[2] = s2;
        a_in = c; a_cv = 1;
        chk("a_chal_ready", a_rdy, 1);
        @(posedge clk); #1;
        a_cv = 0;
        e.raw = er; e.out = eo; e.t0 = edge_cnt; e.lat = 18; e.nl = 3;
        if (push) qa.push_back(e);
        chk("a_puf_chal", a_pchal, c);
        chk("a_busy", a_busy, 1);
    endtask

    task automatic issue_b(input logic [63:0] c, input logic [3:0] s,
                           input logic [3:0] er, input logic eo);
        exp_t e;
        @(negedge clk);
        b_seq = s; b_in = c; b_cv = 1;
        chk("b_chal_ready", b_rdy, 1);
        @(posedge clk); #1;
        b_cv = 0;
        e.raw = er; e.out = eo; e.t0 = edge_cnt; e.lat = 2; e.nl = 1;
        qb.push_back(e);
        chk("b_puf_chal", b_pchal, c);
    endtask

    task automatic drain(input string n);
        int i;
        for (i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            if (qa.size() == 0 && qb.size() == 0) break;
        end
        if (i == 60) chk(n, 0, 1);
    endtask

    initial begin
        #1;
        chk("rst_chal_ready", a_rdy, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_puf_chal", a_pchal, 0);
        repeat (2) @(negedge clk);
        rst = 0; #1;
        chk("post_rst_ready", a_rdy, 1);

        issue_a(64'hDEADBEEF_0123ABCD, 4'b1010, 4'b1010, 4'b1010,
                4'b1010, 1'b0, 1);
        drain("timeout_t1");
        chk("a_chal_hold", a_pchal, 64'hDEADBEEF_0123ABCD);

        issue_a(64'h1111, 4'b0111, 4'b0001, 4'b0011, 4'b0011, 1'b0, 1);
        drain("timeout_t2");
        issue_a(64'h2222, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1);
        drain("timeout_t3");

        // Backpressure: result must stay put and no challenge accepted
        a_rr = 0;
        issue_a(64'h3333, 4'b1110, 4'b0110, 4'b1101, 4'b1110, 1'b1, 1);
        begin : wait_valid
            int i;
            for (i = 0; i < 40; i++) begin
                @(negedge clk);
                if (a_valid) break;
            end
            if (i == 40) chk("timeout_bp", 0, 1);
        end
        a_cv = 1; a_in = 64'h9999;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", a_valid, 1);
            chk("bp_raw", a_raw, 4'b1110);
            chk("bp_out", a_out, 1);
            chk("bp_chal_ready", a_rdy, 0);
        end
        a_cv = 0;
        a_rr = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", a_valid, 0);
        chk("bp_release_ready", a_rdy, 1);
        chk("bp_chal_kept", a_pchal, 64'h3333);

        // Offers while busy are ignored
        issue_a(64'h4444, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 1'b0, 1);
        a_cv = 1; a_in = 64'h5555;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_chal_hold", a_pchal, 64'h4444);
        end
        a_cv = 0;
        drain("timeout_t5");

        // Abort during the second settle window
        issue_a(64'h6666, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 0);
        begin : wait_second
            int i;
            for (i = 0; i < 30; i++) begin
                @(posedge clk); #2;
                if (a_nl == 2) break;
            end
            if (i == 30) chk("timeout_abort", 0, 1);
        end
        @(negedge clk); #2;
        rst = 1; #1;
        chk("abort_busy", a_busy, 0);
        chk("abort_launch", a_launch, 0);
        chk("abort_valid", a_valid, 0);
        chk("abort_raw", a_raw, 0);
        chk("abort_out", a_out, 0);
        chk("abort_puf_chal", a_pchal, 0);
        chk("abort_chal_ready", a_rdy, 0);
        repeat (2) @(negedge clk);
        rst = 0; #1;
        chk("abort_release_ready", a_rdy, 1);
        issue_a(64'h7777, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1);
        drain("timeout_t7");

        issue_b(64'hABCD, 4'b0110, 4'b0110, 1'b0);
        drain("timeout_b1");
        issue_b(64'hBCDE, 4'b1011, 4'b1011, 1'b1);
        drain("timeout_b2");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 Parameter N, 64, challenge width in bits; SHALL match the width of the PUF challenge path.
REQ-002 Parameter K, 4, number of arbiter PUF instances whose responses are combined.
REQ-003 Parameter NREP, 3, evaluations per challenge for majority voting; SHALL be odd and at least 1.
REQ-004 Parameter SETTLE, 4, idle cycles between launch and sample; SHALL be at least 0.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 chal_valid  input  1  challenge offered.
REQ-008 chal_ready  output  1  sequencer can accept a challenge.
REQ-009 chal_in  input  N  challenge to evaluate.
REQ-010 puf_chal  output  N  registered challenge driven to the input network and PUF array.
REQ-011 puf_launch  output  1  one-cycle race launch pulse to the PUF array.
REQ-012 puf_resp  input  K  per-instance arbiter outputs, valid at sample time.
REQ-013 resp_valid  output  1  result available.
REQ-014 resp_ready  input  1  consumer accepts the result.
REQ-015 resp_raw  output  K  per-instance majority-voted bits.
REQ-016 resp_out  output  1  XOR of all resp_raw bits.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, SETTLE, SAMPLE, and DONE.
REQ-019 chal_ready SHALL be 1 only in IDLE. A challenge is accepted on a cycle with chal_valid=1 and chal_ready=1.
REQ-020 On acceptance: puf_chal <= chal_in, vote counters and the evaluation counter clear, and the FSM enters LAUNCH.
REQ-021 puf_chal SHALL hold its value until the next acceptance.
REQ-022 puf_launch SHALL be 1 exactly in LAUNCH. LAUNCH SHALL last 1 cycle, then go to SETTLE, or directly to SAMPLE if SETTLE=0.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, counted by a down-counter, then go to SAMPLE.
REQ-024 In SAMPLE (1 cycle), for each i with puf_resp[i]=1, vote[i] SHALL increment. Each vote counter is clog2(NREP+1) bits wide and SHALL never overflow.
REQ-025 At the end of SAMPLE, the evaluation counter increments. If it reaches NREP, the FSM goes to DONE; otherwise it goes to LAUNCH.
REQ-026 On entering DONE: resp_raw[i] <= (vote[i] > NREP/2, integer division), and resp_out <= XOR reduce of the new resp_raw.
REQ-027 resp_valid SHALL be 1 exactly in DONE. resp_raw and resp_out SHALL be stable while resp_valid=1.
REQ-028 In DONE with resp_ready=1, the FSM SHALL go to IDLE. With resp_ready=0 it SHALL stay in DONE indefinitely.
REQ-029 Latency: for acceptance at edge t0, resp_valid SHALL first assert in cycle t0 + 1 + NREP*(SETTLE+2).
REQ-030 resp_ready asserted outside DONE SHALL have no effect.
REQ-031 chal_valid while busy SHALL be ignored; no challenge is stored.
REQ-032 No new challenge is accepted in the cycle DONE exits; acceptance is possible from the following cycle, in IDLE.
REQ-033 puf_resp SHALL be ignored in all states except SAMPLE.

Reset
REQ-034 While rst=1, the following SHALL apply immediately, regardless of clk: FSM=IDLE, puf_chal=0, puf_launch=0, resp_valid=0, resp_raw=0, resp_out=0, busy=0, all counters=0.
REQ-035 chal_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-evaluation SHALL abort the evaluation. No partial result SHALL be presented.

Verification (N=64, K=4, NREP=3, SETTLE=4)
REQ-037 Accept chal_in=64'hDEADBEEF_0123ABCD with puf_resp held at 4'b1010 -> puf_chal=64'hDEADBEEF_0123ABCD; 3 launch pulses 6 cycles apart; resp_valid at t0+19; resp_raw=4'b1010; resp_out=0.
REQ-038 puf_resp across samples 4'b0111, 4'b0001, 4'b0011 -> resp_raw=4'b0011, resp_out=0. Then samples 4'b1000, 4'b1000, 4'b0000 -> resp_raw=4'b1000, resp_out=1.
REQ-039 resp_ready held 0 for 10 cycles after resp_valid -> outputs stable and chal_ready=0 throughout. resp_ready=1 -> IDLE on the next edge and chal_ready=1.
REQ-040 chal_valid=1 with a different chal_in during an evaluation -> puf_chal unchanged, and the result matches the first challenge.
REQ-041 Assert rst during the second SETTLE -> all outputs zero asynchronously. After release, a new challenge completes with the full 19-cycle latency and votes not carried over.
REQ-042 NREP=1, SETTLE=0 build -> resp_valid at t0+3 and resp_raw equal to puf_resp sampled in the single SAMPLE cycle.
